// File: rtl/nt_level_hysteresis_pkg.sv
// Shared types and helpers for the neurotransmitter level hysteresis filter.
// The level type, FSM state encoding and band-edge arithmetic live here.
package nt_level_hysteresis_pkg;

  typedef logic [1:0] level_t;

  typedef enum logic [1:0] {
    STABLE,
    PEND_UP,
    PEND_DOWN
  } state_t;

  localparam int LEVEL_MAX = 3;

  // Lower edge of band k for an n-bit value: the value range splits into four equal bands.
  function automatic int band_edge(input int k, input int n);
    return k * (1 << (n - 2));
  endfunction

endpackage

// File: rtl/nt_level_hysteresis_if.sv
// Bundle between the resource counter side and the emotional-state logic side
// of one hysteresis filter instance.
interface nt_level_hysteresis_if
  import nt_level_hysteresis_pkg::*;
#(
  parameter int N = 6
);

  logic         tick;
  logic         sync;
  logic [N-1:0] value;
  level_t       level;
  logic         changed;
  logic         rising;

  modport master (
    output tick, sync, value,
    input  level, changed, rising
  );

  modport slave (
    input  tick, sync, value,
    output level, changed, rising
  );

endinterface

// File: rtl/nt_level_hysteresis.sv
// Converts an N-bit resource value into a 2-bit level with hysteresis margins and
// a dwell requirement; the level moves one step at a time, or jumps on sync.
module nt_level_hysteresis
  import nt_level_hysteresis_pkg::*;
#(
  parameter int N             = 6,
  parameter int HYST          = 2,
  parameter int DWELL         = 4,
  parameter int DWELL_W       = 3,
  parameter int DEFAULT_LEVEL = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nt_level_hysteresis_if.slave bus
);

  typedef logic [N:0]       ext_t;
  typedef logic [DWELL_W:0] cnt_ext_t;

  localparam cnt_ext_t DWELL_X = cnt_ext_t'(DWELL);

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  level_t             level_q, level_d;
  logic               changed_q, changed_d;
  logic               rising_q, rising_d;

  ext_t     value_x;
  ext_t     up_thr;
  ext_t     down_thr;
  logic     up_qual;
  logic     down_qual;
  cnt_ext_t cnt_inc;
  level_t   sync_level;

  // Thresholds are compared one bit wider so edge+HYST can never wrap.
  always_comb begin
    value_x   = {1'b0, bus.value};
    up_thr    = ext_t'(band_edge(int'(level_q) + 1, N) + HYST);
    down_thr  = ext_t'(band_edge(int'(level_q), N) - HYST);
    up_qual   = (int'(level_q) < LEVEL_MAX) && (value_x >= up_thr);
    down_qual = (level_q != '0) && (value_x < down_thr);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    changed_d  = 1'b0;
    rising_d   = rising_q;
    cnt_inc    = {1'b0, cnt_q} + cnt_ext_t'(1);
    sync_level = bus.value[N-1:N-2];

    if (bus.sync) begin
      level_d = sync_level;
      state_d = STABLE;
      cnt_d   = '0;
      if (sync_level != level_q) begin
        changed_d = 1'b1;
        rising_d  = (sync_level > level_q);
      end
    end else if (bus.tick) begin
      unique case (state_q)
        STABLE: begin
          cnt_d = '0;
          if (up_qual) begin
            if (DWELL == 1) begin
              level_d   = level_q + 2'd1;
              changed_d = 1'b1;
              rising_d  = 1'b1;
            end else begin
              state_d = PEND_UP;
              cnt_d   = DWELL_W'(1);
            end
          end else if (down_qual) begin
            if (DWELL == 1) begin
              level_d   = level_q - 2'd1;
              changed_d = 1'b1;
              rising_d  = 1'b0;
            end else begin
              state_d = PEND_DOWN;
              cnt_d   = DWELL_W'(1);
            end
          end
        end

        PEND_UP: begin
          if (up_qual) begin
            if (cnt_inc >= DWELL_X) begin
              level_d   = level_q + 2'd1;
              changed_d = 1'b1;
              rising_d  = 1'b1;
              state_d   = STABLE;
              cnt_d     = '0;
            end else begin
              cnt_d = cnt_inc[DWELL_W-1:0];
            end
          end else if (down_qual) begin
            state_d = PEND_DOWN;
            cnt_d   = DWELL_W'(1);
          end else begin
            state_d = STABLE;
            cnt_d   = '0;
          end
        end

        PEND_DOWN: begin
          if (down_qual) begin
            if (cnt_inc >= DWELL_X) begin
              level_d   = level_q - 2'd1;
              changed_d = 1'b1;
              rising_d  = 1'b0;
              state_d   = STABLE;
              cnt_d     = '0;
            end else begin
              cnt_d = cnt_inc[DWELL_W-1:0];
            end
          end else if (up_qual) begin
            state_d = PEND_UP;
            cnt_d   = DWELL_W'(1);
          end else begin
            state_d = STABLE;
            cnt_d   = '0;
          end
        end

        default: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STABLE;
      cnt_q     <= '0;
      level_q   <= level_t'(DEFAULT_LEVEL);
      changed_q <= 1'b0;
      rising_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      changed_q <= changed_d;
      rising_q  <= rising_d;
    end
  end

  assign bus.level   = level_q;
  assign bus.changed = changed_q;
  assign bus.rising  = rising_q;

endmodule
